// File: rtl/async_fifo_lvl_if.sv
// Producer/consumer handshake bundle for async_fifo_lvl.
// master = the user side (producer and consumer); slave = the FIFO itself.
interface async_fifo_lvl_if #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
);
  logic [DATASIZE-1:0] wdata;
  logic                winc;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  modport master (
    output wdata, winc, rinc,
    input  wfull, walmost_full, wlevel, woverflow,
    input  rdata, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  wdata, winc, rinc,
    output wfull, walmost_full, wlevel, woverflow,
    output rdata, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/async_fifo_lvl.sv
// Dual-clock show-ahead FIFO with Gray pointer crossing, fill levels and almost flags.
// Optional sticky overflow/underflow flags: define ASYNC_FIFO_LVL_ERRFLAG_EN.
module async_fifo_lvl #(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = 14,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            rclk,
  input  logic            rrst_n,
  async_fifo_lvl_if.slave bus
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 2 ** ADDRSIZE;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATASIZE-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wlevel_next;
  logic [PW-1:0] wq_rgray;
  logic [PW-1:0] wsync [SYNC_STAGES];
  logic [PW-1:0] wlevel_q;
  logic          wfull_q;
  logic          walmost_q;
  logic          wen;
  logic          wfull_next;
  logic          walmost_next;

  assign wen          = bus.winc & ~wfull_q;
  assign wbin_next    = wbin + PW'(wen);
  assign wgray_next   = wbin_next ^ (wbin_next >> 1);
  assign wq_rgray     = wsync[SYNC_STAGES-1];
  assign wlevel_next  = wbin_next - gray2bin(wq_rgray);
  // Full: same address bits, opposite wrap state (two Gray MSBs inverted)
  assign wfull_next   = (wgray_next == {~wq_rgray[PW-1:PW-2], wq_rgray[PW-3:0]});
  assign walmost_next = (wlevel_next >= PW'(AF_THRESH));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        wsync[i] <= '0;
      end
    end else begin
      wsync[0] <= rgray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        wsync[i] <= wsync[i-1];
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wgray     <= '0;
      wlevel_q  <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
    end else begin
      wbin      <= wbin_next;
      wgray     <= wgray_next;
      wlevel_q  <= wlevel_next;
      wfull_q   <= wfull_next;
      walmost_q <= walmost_next;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge wclk) begin
    if (wen) begin
      mem[wbin[ADDRSIZE-1:0]] <= bus.wdata;
    end
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] rlevel_next;
  logic [PW-1:0] rq_wgray;
  logic [PW-1:0] rsync [SYNC_STAGES];
  logic [PW-1:0] rlevel_q;
  logic          rempty_q;
  logic          ralmost_q;
  logic          ren;
  logic          rempty_next;
  logic          ralmost_next;

  assign ren          = bus.rinc & ~rempty_q;
  assign rbin_next    = rbin + PW'(ren);
  assign rgray_next   = rbin_next ^ (rbin_next >> 1);
  assign rq_wgray     = rsync[SYNC_STAGES-1];
  assign rlevel_next  = gray2bin(rq_wgray) - rbin_next;
  assign rempty_next  = (rgray_next == rq_wgray);
  assign ralmost_next = (rlevel_next <= PW'(AE_THRESH));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        rsync[i] <= '0;
      end
    end else begin
      rsync[0] <= wgray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        rsync[i] <= rsync[i-1];
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rgray     <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      rlevel_q  <= rlevel_next;
      rempty_q  <= rempty_next;
      ralmost_q <= ralmost_next;
    end
  end

  // ---------------- error flags ----------------
`ifdef ASYNC_FIFO_LVL_ERRFLAG_EN
  logic wovf_q;
  logic rudf_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else if (bus.winc && wfull_q) begin
      wovf_q <= 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rudf_q <= 1'b0;
    end else if (bus.rinc && rempty_q) begin
      rudf_q <= 1'b1;
    end
  end

  assign bus.woverflow  = wovf_q;
  assign bus.runderflow = rudf_q;
`else
  assign bus.woverflow  = 1'b0;
  assign bus.runderflow = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign bus.wfull         = wfull_q;
  assign bus.walmost_full  = walmost_q;
  assign bus.wlevel        = wlevel_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_q;
  assign bus.rlevel        = rlevel_q;
  // Show-ahead: head word presented combinationally
  assign bus.rdata         = mem[rbin[ADDRSIZE-1:0]];

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Directed self-checking bench for async_fifo_lvl (default parameters).
`timescale 1ns/1ps
module tb_async_fifo_lvl;

`ifdef ASYNC_FIFO_LVL_ERRFLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic wclk, rclk, wrst_n, rrst_n;
  real  whalf = 5.0;
  real  rhalf = 13.5;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] ref_q [$];

  async_fifo_lvl_if #(.DATASIZE(8), .ADDRSIZE(4)) bus ();

  async_fifo_lvl #(
    .DATASIZE(8), .ADDRSIZE(4), .SYNC_STAGES(2), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #(whalf) wclk = ~wclk;
  end

  // Fractional offset keeps rclk edges from ever coinciding with wclk edges
  initial begin
    rclk = 1'b0;
    #3.3;
    forever #(rhalf) rclk = ~rclk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] d);
    @(negedge wclk);
    bus.winc  = 1'b1;
    bus.wdata = d;
    @(negedge wclk);
    bus.winc  = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d);
    @(negedge rclk);
    d = bus.rdata;
    bus.rinc = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
  endtask

  // {rempty, ralmost_empty, wfull, walmost_full, wlevel, rlevel, woverflow, runderflow}
  function automatic logic [15:0] snap();
    return {bus.rempty, bus.ralmost_empty, bus.wfull, bus.walmost_full,
            bus.wlevel, bus.rlevel, bus.woverflow, bus.runderflow};
  endfunction

  localparam logic [15:0] RST_SNAP = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};

  task automatic test_reset();
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;
    wrst_n = 1'b0; rrst_n = 1'b0;
    repeat (3) @(negedge wclk);
    wrst_n = 1'b1; rrst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      total++;
      if (snap() !== RST_SNAP) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got %h want %h", i, snap(), RST_SNAP);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] d;
    for (int k = 1; k <= 16; k++) begin
      wr(8'(k));
      total++;
      if ({bus.wlevel, bus.wfull, bus.walmost_full} !== {5'(k), (k == 16), (k >= 14)}) begin
        bad++;
        $display("FAIL fill k=%0d: wlevel/wfull/waf got %0d/%b/%b want %0d/%b/%b", k,
                 bus.wlevel, bus.wfull, bus.walmost_full, k, (k == 16), (k >= 14));
      end
    end
    wr(8'hFF);
    total++;
    if ({bus.wfull, bus.wlevel} !== {1'b1, 5'd16}) begin
      bad++;
      $display("FAIL drop_when_full: wfull/wlevel got %b/%0d want 1/16", bus.wfull, bus.wlevel);
    end
    repeat (6) @(negedge rclk);
    total++;
    if ({bus.rempty, bus.ralmost_empty, bus.rlevel} !== {1'b0, 1'b0, 5'd16}) begin
      bad++;
      $display("FAIL full_read_side: rempty/rae/rlevel got %b/%b/%0d want 0/0/16",
               bus.rempty, bus.ralmost_empty, bus.rlevel);
    end
    for (int j = 0; j < 16; j++) begin
      rd(d);
      total++;
      if (d !== 8'(j + 1)) begin
        bad++;
        $display("FAIL drain_data j=%0d: got %h want %h", j, d, 8'(j + 1));
      end
      total++;
      if ({bus.rlevel, bus.ralmost_empty, bus.rempty} !== {5'(15 - j), (15 - j <= 2), (j == 15)}) begin
        bad++;
        $display("FAIL drain_flags j=%0d: rlevel/rae/rempty got %0d/%b/%b want %0d/%b/%b", j,
                 bus.rlevel, bus.ralmost_empty, bus.rempty, 15 - j, (15 - j <= 2), (j == 15));
      end
    end
    repeat (6) @(negedge wclk);
    total++;
    if ({bus.wfull, bus.walmost_full, bus.wlevel} !== {1'b0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL wfull_clear: wfull/waf/wlevel got %b/%b/%0d want 0/0/0",
               bus.wfull, bus.walmost_full, bus.wlevel);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    int n;
    @(negedge wclk);
    bus.wdata = 8'hA5;
    bus.winc  = 1'b1;
    @(posedge wclk);
    fork
      begin #1; bus.winc = 1'b0; end
    join_none
    n = 0;
    while (bus.rempty && n < 8) begin
      @(posedge rclk);
      n++;
      #1;
    end
    total++;
    if (n < 3 || n > 4) begin
      bad++;
      $display("FAIL empty_latency: got %0d rclk edges want 3..4", n);
    end
    total++;
    if ({bus.rdata, bus.rlevel} !== {8'hA5, 5'd1}) begin
      bad++;
      $display("FAIL single_head: rdata/rlevel got %h/%0d want a5/1", bus.rdata, bus.rlevel);
    end
    rd(d);
    total++;
    if ({bus.rempty, bus.rlevel} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL single_pop: rempty/rlevel got %b/%0d want 1/0", bus.rempty, bus.rlevel);
    end
  endtask

  task automatic test_stream();
    int sent, got, wcyc, rcyc, full_seen;
    logic [7:0] exp;
    sent = 0; got = 0; wcyc = 0; rcyc = 0; full_seen = 0;
    ref_q.delete();
    whalf = 10.0;
    rhalf = 10.0;
    repeat (4) @(negedge wclk);
    fork
      begin
        while (sent < 1000 && wcyc < 5000) begin
          @(negedge wclk);
          wcyc++;
          if (!bus.wfull) begin
            bus.winc  = 1'b1;
            bus.wdata = 8'($urandom);
            ref_q.push_back(bus.wdata);
            sent++;
          end else begin
            bus.winc = 1'b0;
            full_seen++;
          end
        end
        @(negedge wclk);
        bus.winc = 1'b0;
      end
      begin
        while (got < 1000 && rcyc < 5000) begin
          @(negedge rclk);
          rcyc++;
          bus.rinc = 1'b0;
          if (!bus.rempty) begin
            exp = (ref_q.size() > 0) ? ref_q.pop_front() : 8'hxx;
            total++;
            if (bus.rdata !== exp) begin
              bad++;
              $display("FAIL stream_data #%0d: got %h want %h", got, bus.rdata, exp);
            end
            got++;
            bus.rinc = 1'b1;
          end
        end
        @(negedge rclk);
        bus.rinc = 1'b0;
      end
    join
    total++;
    if (got != 1000 || ref_q.size() != 0) begin
      bad++;
      $display("FAIL stream_count: got %0d words, %0d left want 1000, 0", got, ref_q.size());
    end
    total++;
    if (full_seen != 0) begin
      bad++;
      $display("FAIL stream_wfull: wfull seen %0d cycles want 0", full_seen);
    end
    repeat (6) @(negedge rclk);
    total++;
    if ({bus.rempty, bus.rlevel} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL stream_end: rempty/rlevel got %b/%0d want 1/0", bus.rempty, bus.rlevel);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int n;
    for (int i = 0; i < 10; i++) wr(8'h40 + 8'(i));
    total++;
    if (bus.wlevel !== 5'd10) begin
      bad++;
      $display("FAIL pre_reset_level: got %0d want 10", bus.wlevel);
    end
    @(negedge wclk);
    wrst_n = 1'b0; rrst_n = 1'b0;
    repeat (2) @(negedge wclk);
    total++;
    if (snap() !== RST_SNAP) begin
      bad++;
      $display("FAIL mid_reset_held: got %h want %h", snap(), RST_SNAP);
    end
    wrst_n = 1'b1; rrst_n = 1'b1;
    repeat (2) @(negedge wclk);
    total++;
    if (snap() !== RST_SNAP) begin
      bad++;
      $display("FAIL mid_reset_after: got %h want %h", snap(), RST_SNAP);
    end
    wr(8'h3C);
    n = 0;
    while (bus.rempty && n < 10) begin
      @(negedge rclk);
      n++;
    end
    total++;
    if ({bus.rempty, bus.rdata} !== {1'b0, 8'h3C}) begin
      bad++;
      $display("FAIL post_reset_head: rempty/rdata got %b/%h want 0/3c", bus.rempty, bus.rdata);
    end
    rd(d);
    total++;
    if (bus.rempty !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_pop: rempty got %b want 1", bus.rempty);
    end
  endtask

  task automatic test_errflags();
    logic [7:0] d;
    @(negedge rclk);
    bus.rinc = 1'b1;
    @(negedge rclk);
    bus.rinc = 1'b0;
    total++;
    if (bus.runderflow !== ERR_EN) begin
      bad++;
      $display("FAIL underflow_set: got %b want %b", bus.runderflow, ERR_EN);
    end
    repeat (5) @(negedge rclk);
    total++;
    if ({bus.runderflow, bus.rempty, bus.rlevel} !== {ERR_EN, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL underflow_sticky: udf/rempty/rlevel got %b/%b/%0d want %b/1/0",
               bus.runderflow, bus.rempty, bus.rlevel, ERR_EN);
    end
    for (int k = 0; k < 16; k++) wr(8'h80 + 8'(k));
    total++;
    if (bus.woverflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_early: got %b want 0", bus.woverflow);
    end
    wr(8'hEE);
    total++;
    if ({bus.woverflow, bus.wfull, bus.wlevel} !== {ERR_EN, 1'b1, 5'd16}) begin
      bad++;
      $display("FAIL overflow_set: ovf/wfull/wlevel got %b/%b/%0d want %b/1/16",
               bus.woverflow, bus.wfull, bus.wlevel, ERR_EN);
    end
    repeat (6) @(negedge rclk);
    for (int j = 0; j < 16; j++) begin
      rd(d);
      total++;
      if (d !== 8'h80 + 8'(j)) begin
        bad++;
        $display("FAIL errflag_data j=%0d: got %h want %h", j, d, 8'h80 + 8'(j));
      end
    end
    total++;
    if ({bus.woverflow, bus.runderflow, bus.rempty} !== {ERR_EN, ERR_EN, 1'b1}) begin
      bad++;
      $display("FAIL flags_final: ovf/udf/rempty got %b/%b/%b want %b/%b/1",
               bus.woverflow, bus.runderflow, bus.rempty, ERR_EN, ERR_EN);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    repeat (4) @(negedge wclk);
    test_single();
    test_stream();
    test_mid_reset();
    test_errflags();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
- Dual-clock FIFO with Gray-coded pointer crossing; second-generation replacement for the basic async FIFO.
- Adds a configurable synchroniser depth, fill-level outputs in both domains, and programmable almost-full/almost-empty flags.
- Sits between a producer on wclk and a consumer on rclk, e.g. ADC capture to DSP, or UART RX to bus.
- Read port is show-ahead: rdata always presents the head word while rempty=0.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, log2 of depth; DEPTH = 2^ADDRSIZE, minimum ADDRSIZE = 2.
- SYNC_STAGES, 2, flops per pointer synchroniser; legal range 2..4.
- AF_THRESH, 14, walmost_full asserts when write-side level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, ralmost_empty asserts when read-side level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  write-domain reset, asynchronous, active-low.
- rclk  in  1  read clock.
- rrst_n  in  1  read-domain reset, asynchronous, active-low.
- wdata  in  DATASIZE  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO full (write domain).
- walmost_full  out  1  level >= AF_THRESH (write domain).
- wlevel  out  ADDRSIZE+1  occupancy seen from the write side, 0..DEPTH.
- woverflow  out  1  sticky write-when-full flag (see Optional Feature).
- rinc  in  1  read request / pop.
- rdata  out  DATASIZE  head word, valid while rempty=0.
- rempty  out  1  FIFO empty (read domain).
- ralmost_empty  out  1  level <= AE_THRESH (read domain).
- rlevel  out  ADDRSIZE+1  occupancy seen from the read side, 0..DEPTH.
- runderflow  out  1  sticky read-when-empty flag (see Optional Feature).

Behaviour:
- Reset values:
  - wrst_n low: wfull=0, walmost_full=0, wlevel=0, woverflow=0; write pointers and write-side synchroniser cleared.
  - rrst_n low: rempty=1, ralmost_empty=1 (AE_THRESH>=0), rlevel=0, runderflow=0; read pointers and read-side synchroniser cleared.
  - Both resets must be asserted together. A mid-operation reset discards all contents; storage RAM is not cleared.
- Pointers: binary counters of ADDRSIZE+1 bits plus registered Gray copies, where Gray = bin ^ (bin>>1). Only the Gray copies cross domains, through SYNC_STAGES-deep flop chains clocked by the destination clock.
- Write: accepted on a wclk edge when winc=1 and wfull=0. The word is stored at waddr = wbin[ADDRSIZE-1:0] and wbin increments. Writes with wfull=1 are dropped, with no pointer or RAM change.
- Read: accepted on an rclk edge when rinc=1 and rempty=0; rbin increments. rdata = mem[rbin[ADDRSIZE-1:0]] combinationally. Reads with rempty=1 do nothing.
- Pointer wrap-around: natural modulo 2^(ADDRSIZE+1). The MSB distinguishes full from empty.
- wfull (registered): set when the next write Gray pointer equals the synchronised read Gray pointer with its two MSBs inverted and the remaining bits equal.
- rempty (registered): set when the next read Gray pointer equals the synchronised write Gray pointer.
- Levels, registered every edge:
  - wlevel = wbinnext - gray2bin(sync rptr), mod 2^(ADDRSIZE+1).
  - rlevel = gray2bin(sync wptr) - rbinnext.
  - Both are conservative: wlevel over-reports and rlevel under-reports by up to the synchroniser latency.
- Almost flags, registered:
  - walmost_full = (next wlevel >= AF_THRESH).
  - ralmost_empty = (next rlevel <= AE_THRESH).
- Flag timing:
  - The same wclk edge that accepts a write updates wlevel, wfull and walmost_full.
  - rempty falls on the (SYNC_STAGES+1)th rclk edge after the wclk edge that wrote into an empty FIFO, with +1 edge tolerance for clock phase.
  - wfull clears symmetrically, SYNC_STAGES+1 wclk edges after a pop.
- Simultaneous winc and rinc: each is judged independently against its own domain flag. A write on the edge where the FIFO goes full still succeeds; the next write is dropped.
- Throughput: one write per wclk and one read per rclk, sustained.

Optional Feature:
- Macro: ASYNC_FIFO_LVL_ERRFLAG_EN.
- Defined:
  - woverflow sets on a wclk edge with winc=1 and wfull=1.
  - runderflow sets on an rclk edge with rinc=1 and rempty=1.
  - Both are sticky until their own domain's reset.
  - Data and pointer behaviour are unchanged.
- Undefined: woverflow and runderflow are tied to 0 and the detection logic is not built.

Test Plan:
- Reset then idle, wclk 100 MHz, rclk 37 MHz → rempty=1, ralmost_empty=1, wfull=0, wlevel=0, rlevel=0 throughout.
- Write 0x01..0x10 (16 words, defaults), no reads → wfull=1 after the 16th accept; walmost_full=1 from the 14th accept; wlevel=16; a 17th write of 0xFF is dropped; reading all 16 returns 0x01..0x10 in order, then rempty=1.
- Single write 0xA5 into an empty FIFO → rempty falls within 3–4 rclk edges; rdata=0xA5 while rempty=0; a pop gives rempty=1, rlevel=0.
- Continuous write and read with both clocks at 50 MHz, phase offset, 1000 random words → no loss or reorder; wfull is never seen; the read-back sequence matches a reference queue; pointers wrap at least 60 times.
- Fill to 10 words, assert wrst_n and rrst_n together for 2 cycles → all outputs return to reset values; the next written word 0x3C is the next word read.
- With ASYNC_FIFO_LVL_ERRFLAG_EN: rinc while empty → runderflow=1 and stays set; write when full → woverflow=1. Without the macro, the same stimulus leaves both flags at 0.
